// File: rtl/jk_up_counter.sv
// jk_up_counter: binary up counter whose state bits are individual JK cells, with a
// programmable terminal value, tc and wrap. Define JK_UP_CNT_LOAD_EN to add the load/d ports.
module jk_up_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef JK_UP_CNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic             at_max;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             wrap_nxt;
    logic             wrap_p1;

    // ">=" so that a loaded value above the terminal value still wraps on the next count
    assign at_max = (q >= MAX_Q);
    assign tc     = en & at_max;

    always_comb begin
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & q[i-1];
        end
    end

    always_comb begin
        j        = '0;
        k        = '0;
        wrap_nxt = 1'b0;
`ifdef JK_UP_CNT_LOAD_EN
        if (load) begin
            j = d;
            k = ~d;
        end else
`endif
        if (en) begin
            if (at_max) begin
                k        = '1;
                wrap_nxt = 1'b1;
            end else begin
                j = t;
                k = t;
            end
        end
    end

    // Stage p1: JK cells and the registered wrap pulse
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic qb;

        always_ff @(posedge clk) begin
            if (!rst) begin
                qb <= 1'b0;
            end else begin
                case ({j[i], k[i]})
                    2'b01:   qb <= 1'b0;
                    2'b10:   qb <= 1'b1;
                    2'b11:   qb <= ~qb;
                    default: qb <= qb;
                endcase
            end
        end

        assign q[i] = qb;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_p1 <= 1'b0;
        end else begin
            wrap_p1 <= wrap_nxt;
        end
    end

    assign wrap = wrap_p1;

endmodule

// File: tb/tb_jk_up_counter.sv
// Self-checking bench for jk_up_counter: directed scenarios, randomized traffic against an
// arithmetic reference model, and a two-stage decimal cascade.
module tb_jk_up_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       en  = 1'b0;
`ifdef JK_UP_CNT_LOAD_EN
    logic       load = 1'b0;
    logic [3:0] d    = '0;
`endif
    logic [3:0] q9, q15;
    logic       tc9, tc15, wrap9, wrap15;

    logic       crst = 1'b0;
    logic       cen  = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int m9  = 0;
    int m15 = 0;
    bit mw9  = 1'b0;
    bit mw15 = 1'b0;

    jk_up_counter #(.WIDTH(4), .MAX_COUNT(9)) u_dut9 (
        .clk(clk), .rst(rst), .en(en),
`ifdef JK_UP_CNT_LOAD_EN
        .load(load), .d(d),
`endif
        .q(q9), .tc(tc9), .wrap(wrap9)
    );

    jk_up_counter #(.WIDTH(4)) u_dut15 (
        .clk(clk), .rst(rst), .en(en),
`ifdef JK_UP_CNT_LOAD_EN
        .load(load), .d(d),
`endif
        .q(q15), .tc(tc15), .wrap(wrap15)
    );

    jk_up_counter #(.WIDTH(4), .MAX_COUNT(9)) u_lo (
        .clk(clk), .rst(crst), .en(cen),
`ifdef JK_UP_CNT_LOAD_EN
        .load(1'b0), .d(4'd0),
`endif
        .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
    );

    jk_up_counter #(.WIDTH(4), .MAX_COUNT(9)) u_hi (
        .clk(clk), .rst(crst), .en(lo_tc),
`ifdef JK_UP_CNT_LOAD_EN
        .load(1'b0), .d(4'd0),
`endif
        .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: a counter that counts 0..maxc and then returns to 0
    function automatic void ref_step(inout int mq, inout bit mw, input int maxc,
                                     input bit r, input bit e, input bit l, input int dv);
        if (!r) begin
            mq = 0;
            mw = 1'b0;
        end else if (l) begin
            mq = dv;
            mw = 1'b0;
        end else if (e && mq >= maxc) begin
            mq = 0;
            mw = 1'b1;
        end else if (e) begin
            mq = mq + 1;
            mw = 1'b0;
        end else begin
            mw = 1'b0;
        end
    endfunction

    task automatic step(input bit r, input bit e, input bit l, input int dv);
`ifndef JK_UP_CNT_LOAD_EN
        l = 1'b0;
`endif
        @(negedge clk);
        rst = r;
        en  = e;
`ifdef JK_UP_CNT_LOAD_EN
        load = l;
        d    = dv[3:0];
`endif
        @(posedge clk);
        ref_step(m9, mw9, 9, r, e, l, dv);
        ref_step(m15, mw15, 15, r, e, l, dv);
        #1;
        chk("q9", 32'(q9), m9);
        chk("wrap9", 32'(wrap9), 32'(mw9));
        chk("tc9", 32'(tc9), 32'(e && m9 >= 9));
        chk("q15", 32'(q15), m15);
        chk("wrap15", 32'(wrap15), 32'(mw15));
        chk("tc15", 32'(tc15), 32'(e && m15 >= 15));
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 40 && m9 != target; i++) begin
            step(1'b1, 1'b1, 1'b0, 0);
        end
        chk("reach_target", 32'(q9), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two edges, then count through a full decade
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 0);
        end

        // Hold at 5, then resume
        run_to(5);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 0);
        end
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);

`ifdef JK_UP_CNT_LOAD_EN
        // Out-of-range load wraps on the next enabled edge
        step(1'b1, 1'b1, 1'b1, 13);
        step(1'b1, 1'b1, 1'b0, 0);
        // Load beats wrap at the terminal value
        run_to(9);
        step(1'b1, 1'b1, 1'b1, 3);
        // Load without enable, then hold and wrap
        step(1'b1, 1'b0, 1'b1, 11);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
`endif

        // Reset overrides load and enable mid-count
        run_to(7);
        step(1'b0, 1'b1, 1'b1, 4);
        step(1'b1, 1'b1, 1'b0, 0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 10), int'($urandom_range(0, 15)));
        end

        // Two-digit decimal cascade
        @(negedge clk);
        crst = 1'b0;
        cen  = 1'b0;
        @(posedge clk);
        #1;
        chk("cascade_reset", 32'(hi_q * 10 + lo_q), 0);
        @(negedge clk);
        crst = 1'b1;
        cen  = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            chk("cascade_count", 32'(int'(hi_q) * 10 + int'(lo_q)), n % 100);
            chk("cascade_hi_wrap", 32'(hi_wrap), 32'(n == 100));
            chk("cascade_lo_wrap", 32'(lo_wrap), 32'(n % 10 == 0));
            chk("cascade_hi_tc", 32'(hi_tc), 32'(n % 100 == 99));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_up_counter.md
# jk_up_counter

Parameterised synchronous binary up counter built from per-bit JK flip-flop cells, with count enable, programmable terminal value, terminal-count and wrap outputs. It is the count-up counterpart to the lab's JK down counter: it feeds cascaded counter chains and the clock-divider and timer exercises, where `tc` of one stage enables the next. All state changes occur on the rising edge of `clk`.

## Interface
- `WIDTH`, 4, counter width in bits (1..16).
- `MAX_COUNT`, 2**WIDTH-1, terminal value; the counter wraps to 0 after it (must be < 2**WIDTH).

- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk` only.
- `en`  input  1  count enable; increment when high.
- `load`  input  1  synchronous parallel load strobe (present only with `JK_UP_CNT_LOAD_EN`).
- `d`  input  WIDTH  parallel load value (present only with `JK_UP_CNT_LOAD_EN`).
- `q`  output  WIDTH  current count.
- `tc`  output  1  combinational terminal count: `en & (q >= MAX_COUNT)`.
- `wrap`  output  1  registered one-cycle pulse, high in the cycle after a wrap to 0.

## Operation
- Each bit of `q` is held in its own JK cell: 00 hold, 01 clear, 10 set, 11 toggle. A JK cell has a synchronous active-low clear.
- Next state is formed only by driving J and K. No behavioural `q+1` on the state register.
- Priority per edge: `rst` low, then `load`, then `en`, then hold.
- Reset (`rst`=0): `q`=0 and `wrap`=0. `tc`=0 follows from this.
- Count (`en`=1, `q` < `MAX_COUNT`): bit i gets J=K=T_i, where T_0=1 and T_i=&q[i-1:0]. Result: `q` ← `q`+1.
- Wrap (`en`=1, `q` >= `MAX_COUNT`): every bit gets J=0, K=1. Result: `q` ← 0, and `wrap` ← 1 on the same edge.
- `wrap` is cleared on every other edge.
- Hold (`en`=0): J=K=0 on all bits; `q` and `tc` stay stable.
- Load (`load`=1): bit i gets J=`d`[i], K=~`d`[i]. Result: `q` ← `d`, `wrap` ← 0, and `en` is ignored that cycle.
- A loaded value above `MAX_COUNT` is accepted unchanged. The next enabled edge wraps it to 0, because the wrap condition is `>=`.
- Cascading: drive the next stage's `en` from this stage's `tc`. The chain then advances exactly once per wrap.

## Timing
- Latency: every control input takes effect on the first rising edge at which it is sampled; `q` is valid one edge later.
- `tc` is combinational from `q` and `en`, with zero-cycle latency. It has no path from `load` or `d`.
- `wrap` is high for exactly one cycle, the cycle in which `q`=0 after a wrap.
- Reset mid-count overrides `load` and `en` on the same edge. The counter resumes from 0 on the first edge with `rst`=1.
- Simultaneous `load`=1 and `en`=1 at `q`=`MAX_COUNT`: the load wins, `wrap` stays 0 and `q`=`d`.
- `MAX_COUNT`=2**WIDTH-1: the wrap equals natural binary rollover, with the same `wrap` behaviour.
- `WIDTH`=1: the counter is a T flip-flop; `tc`=`en & q`.

## Configuration
- `JK_UP_CNT_LOAD_EN` defined: the `load` and `d` ports exist and load behaves as above.
- `JK_UP_CNT_LOAD_EN` undefined: the `load` and `d` ports are removed, the load mux is not built, and priority reduces to reset, count, hold. All other behaviour is identical.

## Test plan
- Reset and count, with `WIDTH`=4, `MAX_COUNT`=9: hold `rst`=0 for 2 edges, then release with `en`=1.
  - Required: `q` = 0,1,…,9,0,1.
  - `tc`=1 only while `q`=9.
  - `wrap`=1 only in the cycle where `q` returns to 0.
- Hold at `q`=5: drop `en` for 3 edges. Required: `q` stays 5 and `tc`=0 throughout; counting resumes 6,7 once `en`=1.
- Load out of range (`JK_UP_CNT_LOAD_EN`): pulse `load` with `d`=13 and `en`=1.
  - Required: `q`=13 on the first edge, `q`=0 on the next edge, and `wrap`=1 on that cycle.
- Load vs wrap collision: at `q`=9, assert `load`=1, `d`=3, `en`=1 together. Required: `q`=3 and `wrap`=0.
- Reset mid-operation: assert `rst`=0 at `q`=7 with `en`=1 and `load`=1.
  - Required: `q`=0 and `wrap`=0 on that edge.
  - Required: `q`=1 after the first edge with `rst`=1.
- Cascade: two instances with `WIDTH`=4, `MAX_COUNT`=9, the upper stage's `en` driven by the lower stage's `tc`, run for 100 edges.
  - Required: the counts read 99, then 00 with the upper stage's `wrap`=1.
  - Repeat with the macro undefined to confirm the design builds without `load`/`d`.
